// File: rtl/router_sync_n.sv
// router_sync_n: synchroniser between a 1xN router FSM and its N output FIFOs.
// Captures the destination address, steers the write enable and full status,
// exports per-port valid and raises a one-cycle soft reset on any port whose
// valid data sits unread for TIMEOUT consecutive cycles.
module router_sync_n #(
  parameter  int unsigned NUM_PORTS = 3,
  parameter  int unsigned TIMEOUT   = 30,
  localparam int unsigned ADDR_W    = ($clog2(NUM_PORTS) > 1) ? $clog2(NUM_PORTS) : 1,
  localparam int unsigned CNT_W     = $clog2(TIMEOUT)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [ADDR_W-1:0]    data_in,
  input  logic                 detect_add,
  input  logic                 write_enb_reg,
  input  logic [NUM_PORTS-1:0] full,
  input  logic [NUM_PORTS-1:0] empty,
  input  logic [NUM_PORTS-1:0] read_enb,
  output logic [NUM_PORTS-1:0] write_enb,
  output logic                 fifo_full,
  output logic [NUM_PORTS-1:0] vld_out,
  output logic [NUM_PORTS-1:0] soft_reset,
  output logic                 addr_err
);

  // One extra bit so NUM_PORTS itself is representable for the range check.
  localparam logic [ADDR_W:0]  NUM_PORTS_W = (ADDR_W+1)'(NUM_PORTS);
  localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(TIMEOUT - 1);

  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic                 addr_valid_q, addr_valid_d;
  logic                 addr_err_q, addr_err_d;
  logic [CNT_W-1:0]     cnt_q [NUM_PORTS];
  logic [CNT_W-1:0]     cnt_d [NUM_PORTS];
  logic [NUM_PORTS-1:0] soft_reset_q, soft_reset_d;
  logic                 addr_in_range;

  assign addr_in_range = ({1'b0, data_in} < NUM_PORTS_W);

  // Address capture on header strobe; an out-of-range address invalidates
  // the current destination but leaves the last good address in place.
  always_comb begin
    addr_d       = addr_q;
    addr_valid_d = addr_valid_q;
    addr_err_d   = addr_err_q;
    if (detect_add) begin
      if (addr_in_range) begin
        addr_d       = data_in;
        addr_valid_d = 1'b1;
        addr_err_d   = 1'b0;
      end else begin
        addr_valid_d = 1'b0;
        addr_err_d   = 1'b1;
      end
    end
  end

  // Address register.
  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q       <= '0;
      addr_valid_q <= 1'b0;
      addr_err_q   <= 1'b0;
    end else begin
      addr_q       <= addr_d;
      addr_valid_q <= addr_valid_d;
      addr_err_q   <= addr_err_d;
    end
  end

  // Steer write enable and select full flag of the registered destination.
  always_comb begin
    write_enb = '0;
    fifo_full = 1'b0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (addr_q == ADDR_W'(i)) begin
        write_enb[i] = write_enb_reg & addr_valid_q & ~reset;
        fifo_full    = full[i] & addr_valid_q & ~reset;
      end
    end
  end

  assign vld_out = ~empty;

  // Per-port idle-valid counters; a pulse is issued as the counter wraps to 0.
  always_comb begin
    soft_reset_d = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (empty[i] || read_enb[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        cnt_d[i]        = '0;
        soft_reset_d[i] = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // Timeout counter and soft-reset pulse registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) cnt_q[i] <= '0;
      soft_reset_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) cnt_q[i] <= cnt_d[i];
      soft_reset_q <= soft_reset_d;
    end
  end

  assign soft_reset = soft_reset_q;
  assign addr_err   = addr_err_q;

endmodule

// File: tb/tb_router_sync_n.sv
// Scoreboard bench for router_sync_n: two instances (3 ports / timeout 30 and
// 8 ports / timeout 4) driven with directed and random stimulus, compared
// cycle by cycle against a behavioural model.
module tb_router_sync_n;

  localparam int N0 = 3;
  localparam int T0 = 30;
  localparam int N1 = 8;
  localparam int T1 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus (index 0 -> 3-port DUT, index 1 -> 8-port DUT)
  logic        rst;
  logic [3:0]  din     [2];
  logic        det     [2];
  logic        wer     [2];
  logic [15:0] full_s  [2];
  logic [15:0] empty_s [2];
  logic [15:0] rd_s    [2];

  logic [2:0] we0, vld0, sr0;
  logic       ff0, err0;
  logic [7:0] we1, vld1, sr1;
  logic       ff1, err1;

  router_sync_n #(.NUM_PORTS(N0), .TIMEOUT(T0)) u_dut0 (
    .clock(clk), .reset(rst), .data_in(din[0][1:0]), .detect_add(det[0]),
    .write_enb_reg(wer[0]), .full(full_s[0][2:0]), .empty(empty_s[0][2:0]),
    .read_enb(rd_s[0][2:0]), .write_enb(we0), .fifo_full(ff0), .vld_out(vld0),
    .soft_reset(sr0), .addr_err(err0));

  router_sync_n #(.NUM_PORTS(N1), .TIMEOUT(T1)) u_dut1 (
    .clock(clk), .reset(rst), .data_in(din[1][2:0]), .detect_add(det[1]),
    .write_enb_reg(wer[1]), .full(full_s[1][7:0]), .empty(empty_s[1][7:0]),
    .read_enb(rd_s[1][7:0]), .write_enb(we1), .fifo_full(ff1), .vld_out(vld1),
    .soft_reset(sr1), .addr_err(err1));

  typedef struct {
    logic [15:0] we, vld, sr;
    logic        ff, err;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int checks   = 0;
  int failures = 0;

  // Reference state: destination and, per port, length of the current run of
  // consecutive idle-valid edges since the last read/empty/reset.
  int m_addr  [2];
  bit m_valid [2];
  bit m_err   [2];
  int m_run   [2][16];

  function automatic int nports(int d);
    return (d == 0) ? N0 : N1;
  endfunction

  function automatic int tmo(int d);
    return (d == 0) ? T0 : T1;
  endfunction

  task automatic model_edge(int d);
    if (rst) begin
      m_addr[d] = 0; m_valid[d] = 0; m_err[d] = 0;
      for (int i = 0; i < 16; i++) m_run[d][i] = 0;
    end else begin
      if (det[d]) begin
        if (int'(din[d]) < nports(d)) begin
          m_addr[d] = int'(din[d]); m_valid[d] = 1; m_err[d] = 0;
        end else begin
          m_valid[d] = 0; m_err[d] = 1;
        end
      end
      for (int i = 0; i < nports(d); i++)
        if (!empty_s[d][i] && !rd_s[d][i]) m_run[d][i]++;
        else m_run[d][i] = 0;
    end
  endtask

  function automatic exp_t predict(int d);
    exp_t e;
    logic [15:0] mask;
    mask  = (16'(1) << nports(d)) - 16'(1);
    e.we  = (!rst && wer[d] && m_valid[d]) ? (16'(1) << m_addr[d]) : 16'h0;
    e.ff  = (!rst && m_valid[d]) ? full_s[d][m_addr[d]] : 1'b0;
    e.vld = ~empty_s[d] & mask;
    e.err = m_err[d];
    e.sr  = '0;
    for (int i = 0; i < nports(d); i++)
      e.sr[i] = (m_run[d][i] > 0) && (m_run[d][i] % tmo(d) == 0);
    return e;
  endfunction

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  // Monitor: compare DUT outputs against queued expectations away from posedge.
  always @(negedge clk) begin
    exp_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      chk("dut0.write_enb",  {13'b0, we0},  e.we);
      chk("dut0.fifo_full",  {15'b0, ff0},  {15'b0, e.ff});
      chk("dut0.vld_out",    {13'b0, vld0}, e.vld);
      chk("dut0.soft_reset", {13'b0, sr0},  e.sr);
      chk("dut0.addr_err",   {15'b0, err0}, {15'b0, e.err});
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk("dut1.write_enb",  {8'b0, we1},   e.we);
      chk("dut1.fifo_full",  {15'b0, ff1},  {15'b0, e.ff});
      chk("dut1.vld_out",    {8'b0, vld1},  e.vld);
      chk("dut1.soft_reset", {8'b0, sr1},   e.sr);
      chk("dut1.addr_err",   {15'b0, err1}, {15'b0, e.err});
    end
  end

  // Record expectation for the currently applied inputs, then advance one edge.
  task automatic cycle();
    q0.push_back(predict(0));
    q1.push_back(predict(1));
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
  endtask

  task automatic cycles(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      din[d] = '0; det[d] = 0; wer[d] = 0;
      full_s[d] = '0; empty_s[d] = 16'h00FF; rd_s[d] = '0;
    end
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    cycles(2);
    rst = 1'b0;

    // Address capture and steering; dut1 targets port 7 and idles it.
    det[0] = 1; din[0] = 4'd1;
    det[1] = 1; din[1] = 4'd7; empty_s[1] = 16'h007F;
    cycle();
    det[0] = 0; det[1] = 0; wer[0] = 1; wer[1] = 1;
    full_s[0] = 16'h0002; full_s[1] = 16'h0080;
    cycle();
    full_s[0] = 16'h0005;
    cycle();

    // Out-of-range address then recovery.
    det[0] = 1; din[0] = 4'd3;
    cycle();
    det[0] = 0;
    cycles(2);
    det[0] = 1; din[0] = 4'd2;
    cycle();
    det[0] = 0;
    cycles(2);
    wer[0] = 0;

    // Port 0 idle-valid for two full timeout periods.
    empty_s[0] = 16'h0006;
    cycles(65);
    empty_s[0] = 16'h0007;
    cycles(3);

    // Read pulse mid-count restarts the timeout.
    empty_s[0] = 16'h0006;
    cycles(25);
    rd_s[0] = 16'h0001;
    cycle();
    rd_s[0] = '0;
    cycles(35);
    empty_s[0] = 16'h0007;
    cycles(3);

    // Ports 0 and 2 together: one simultaneous pulse, then reset mid-count.
    empty_s[0] = 16'h0002;
    cycles(32);
    empty_s[0] = 16'h0007;
    cycle();
    empty_s[0] = 16'h0002;
    cycles(20);
    rst = 1;
    cycle();
    rst = 0;
    cycles(35);

    // Random traffic on both instances.
    for (int k = 0; k < 1500; k++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int d = 0; d < 2; d++) begin
        det[d]    = ($urandom_range(0, 3) == 0);
        din[d]    = (d == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 7));
        wer[d]    = $urandom_range(0, 1) == 1;
        full_s[d] = 16'($urandom) & ((16'(1) << nports(d)) - 16'(1));
        for (int i = 0; i < nports(d); i++) begin
          if ($urandom_range(0, 31) == 0) empty_s[d][i] = ~empty_s[d][i];
          rd_s[d][i] = ($urandom_range(0, 39) == 0);
        end
      end
      cycle();
    end

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
